// File: rtl/prog_pkg.sv
// Shared types and constants for the configuration scan-chain loader.
package prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FIN,
    DONE,
    ERR
  } prog_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/prog_chain_loader_if.sv
// Bitstream word stream (valid/ready) feeding the scan-chain loader.
interface prog_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/prog_crc16_serial.sv
// Bit-serial CRC-16-CCITT (MSB-first, no reflection) with synchronous clear and enable.
module prog_crc16_serial
  import prog_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = r_crc[15] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_crc <= CRC16_INIT;
    end else if (i_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ ({16{w_fb}} & CRC16_POLY);
    end
  end
endmodule

// File: rtl/prog_chain_loader.sv
// Scan-chain configuration loader: serializes stream words MSB-first onto prog_in/prog_en.
// Optional CRC-16 check of the shifted bits when PROG_CRC_EN is defined.
module prog_chain_loader
  import prog_pkg::*;
#(
  parameter  int WORD_W    = 32,
  parameter  int CHAIN_LEN = 4096,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               prog_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  prog_chain_loader_if.slave s,
  input  logic [15:0]        crc_expected,
  output logic               prog_in,
  output logic               prog_en,
  output logic               busy,
  output logic               done,
  output logic               cfg_loaded,
  output logic               cfg_error,
  output logic [CNT_W-1:0]   bits_left
);
  localparam int WC_W = $clog2(WORD_W + 1);

  prog_state_t       r_state, w_next;
  logic [WORD_W-1:0] r_shreg;
  logic [WC_W-1:0]   r_word_cnt, w_word_n;
  logic [CNT_W-1:0]  r_bits_left;
  logic [31:0]       w_rem;
  logic              r_loaded;
  logic              w_idle, w_busy, w_shift, w_last_bit, w_more;
  logic              w_start, w_ready, w_take, w_crc_ok;

  always_ff @(posedge prog_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_idle     = r_state inside {IDLE, DONE, ERR};
    w_busy     = r_state inside {LOAD, SHIFT, FIN};
    w_shift    = (r_state == SHIFT);
    w_last_bit = (r_word_cnt == WC_W'(1));
    w_more     = (r_bits_left > CNT_W'(1));
    w_start    = start && !abort && w_idle;
    w_ready    = !abort && ((r_state == LOAD) || (w_shift && w_last_bit && w_more));
    w_take     = w_ready && s.s_valid;
    // A word taken on its predecessor's last bit sees one bit fewer remaining.
    w_rem      = w_shift ? 32'(r_bits_left) - 32'd1 : 32'(r_bits_left);
    w_word_n   = (w_rem >= 32'(WORD_W)) ? WC_W'(WORD_W) : WC_W'(w_rem);
    prog_en    = w_shift;
    prog_in    = w_shift & r_shreg[WORD_W-1];
    busy       = w_busy;
    done       = (r_state == DONE) || (r_state == ERR);
    unique case (r_state)
      IDLE, DONE, ERR: w_next = w_start ? LOAD : IDLE;
      LOAD: begin
        if (abort)       w_next = IDLE;
        else if (w_take) w_next = SHIFT;
      end
      SHIFT: begin
        if (abort)           w_next = IDLE;
        else if (!w_more)    w_next = FIN;
        else if (w_last_bit) w_next = w_take ? SHIFT : LOAD;
      end
      FIN: begin
        if (abort) w_next = IDLE;
        else       w_next = w_crc_ok ? DONE : ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  assign s.s_ready  = w_ready;
  assign bits_left  = r_bits_left;
  assign cfg_loaded = r_loaded;

  always_ff @(posedge prog_clk) begin
    if (rst || (abort && w_busy)) begin
      r_shreg     <= '0;
      r_word_cnt  <= '0;
      r_bits_left <= '0;
      r_loaded    <= 1'b0;
    end else begin
      if (w_start) begin
        r_bits_left <= CNT_W'(CHAIN_LEN);
        r_loaded    <= 1'b0;
      end
      if (w_shift) r_bits_left <= r_bits_left - CNT_W'(1);
      if (w_take) begin
        r_shreg    <= s.s_data;
        r_word_cnt <= w_word_n;
      end else if (w_shift) begin
        r_shreg    <= r_shreg << 1;
        r_word_cnt <= r_word_cnt - WC_W'(1);
      end
      if (r_state == FIN) r_loaded <= w_crc_ok;
    end
  end

`ifdef PROG_CRC_EN
  logic [15:0] r_crc_exp, w_crc;
  logic        r_error;

  prog_crc16_serial u_crc (
    .clk   (prog_clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_shift),
    .i_bit (r_shreg[WORD_W-1]),
    .o_crc (w_crc)
  );

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_crc_exp <= '0;
      r_error   <= 1'b0;
    end else if (abort && w_busy) begin
      r_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_crc_exp <= crc_expected;
        r_error   <= 1'b0;
      end
      if (r_state == FIN) r_error <= !w_crc_ok;
    end
  end

  assign w_crc_ok  = (w_crc == r_crc_exp);
  assign cfg_error = r_error;
`else
  logic w_unused_crc;
  assign w_unused_crc = ^crc_expected;
  assign w_crc_ok     = 1'b1;
  assign cfg_error    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_chain_loader.sv
// Directed bench for prog_chain_loader: 70-bit chain loaded from three 32-bit words.
module tb_prog_chain_loader;
  localparam int WORD_W    = 32;
  localparam int CHAIN_LEN = 70;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [69:0] EXP_BITS = {32'hA5A5A5A5, 32'h0F0F0F0F, 6'b111111};

  logic             prog_clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [15:0]      crc_expected = '0;
  logic             prog_in, prog_en, busy, done, cfg_loaded, cfg_error;
  logic [CNT_W-1:0] bits_left;

  prog_chain_loader_if #(.WORD_W(WORD_W)) s_if ();

  prog_chain_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .prog_clk     (prog_clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .s            (s_if),
    .crc_expected (crc_expected),
    .prog_in      (prog_in),
    .prog_en      (prog_en),
    .busy         (busy),
    .done         (done),
    .cfg_loaded   (cfg_loaded),
    .cfg_error    (cfg_error),
    .bits_left    (bits_left)
  );

  always #5 prog_clk = ~prog_clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  words [3];
  int           en_cycles, en_rises, done_cnt, first_en, last_en, step_no, bl_at35;
  logic         prev_en;
  logic [127:0] bits;
  logic         hs_idle;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef PROG_CRC_EN
  function automatic logic [15:0] crc_of(input logic [69:0] b);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 69; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`endif

  // Samples one cycle at the falling edge, then advances to just after the next rising edge.
  task automatic step(output logic hs);
    @(negedge prog_clk);
    if (prog_en) begin
      en_cycles++;
      bits = {bits[126:0], prog_in};
      if (!prev_en) en_rises++;
      if (first_en < 0) first_en = step_no;
      last_en = step_no;
      if (en_cycles == 35) bl_at35 = int'(bits_left);
    end
    prev_en = prog_en;
    if (done) done_cnt++;
    hs = s_if.s_valid && s_if.s_ready;
    step_no++;
    @(posedge prog_clk);
    #1;
  endtask

  // evt_kind: 0 none, 1 abort, 2 start, 3 rst -- applied for one cycle after bit evt_bit.
  task automatic run_load(input int gap, input int evt_bit, input int evt_kind,
                          input logic [15:0] crc);
    logic hs;
    int   idx, gap_left, post_done;
    bit   fin, evt_done, evt_armed;
    en_cycles = 0; en_rises = 0; done_cnt = 0; first_en = -1; last_en = -1;
    step_no = 0; bl_at35 = -1; prev_en = 1'b0; bits = '0;
    idx = 0; gap_left = gap; post_done = 0; fin = 0; evt_done = 0; evt_armed = 0;
    crc_expected = crc;
    start = 1'b1;
    step(hs);
    start = 1'b0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = words[0];
    check("load_busy", 128'(busy), 128'(1));
    check("load_s_ready", 128'(s_if.s_ready), 128'(1));
    check("load_bits_left", 128'(bits_left), 128'(CHAIN_LEN));
    for (int c = 0; c < 300 && !fin; c++) begin
      step(hs);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (evt_armed) begin
        s_if.s_valid = 1'b0;
        check("evt_prog_en", 128'(prog_en), 128'(0));
        check("evt_busy", 128'(busy), 128'(0));
        check("evt_s_ready", 128'(s_if.s_ready), 128'(0));
        check("evt_cfg_loaded", 128'(cfg_loaded), 128'(0));
        check("evt_done", 128'(done), 128'(0));
        if (evt_kind == 3) begin
          check("rst_bits_left", 128'(bits_left), 128'(0));
          check("rst_prog_in", 128'(prog_in), 128'(0));
          check("rst_cfg_error", 128'(cfg_error), 128'(0));
        end
        fin = 1;
      end else begin
        if (hs) idx++;
        if (en_cycles >= 32 && gap_left > 0) gap_left--;
        s_if.s_valid = (idx < 3) && !(idx == 1 && gap_left > 0);
        s_if.s_data  = (idx < 3) ? words[idx] : '0;
        if (evt_kind != 0 && !evt_done && en_cycles == evt_bit) begin
          evt_done = 1;
          case (evt_kind)
            1:       abort = 1'b1;
            2:       start = 1'b1;
            default: rst   = 1'b1;
          endcase
          evt_armed = (evt_kind != 2);
        end
        if (done_cnt > 0) post_done++;
        if (post_done == 3) fin = 1;
      end
    end
    check("load_terminated", 128'(fin), 128'(1));
    s_if.s_valid = 1'b0;
  endtask

  task automatic check_full(input string tag, input int exp_span, input int exp_rises,
                            input logic exp_loaded, input logic exp_error);
    check({tag, "_en_cycles"}, 128'(en_cycles), 128'(CHAIN_LEN));
    check({tag, "_en_span"}, 128'(last_en - first_en + 1), 128'(exp_span));
    check({tag, "_en_rises"}, 128'(en_rises), 128'(exp_rises));
    check({tag, "_bits"}, 128'(bits[69:0]), 128'(EXP_BITS));
    check({tag, "_bits_left_mid"}, 128'(bl_at35), 128'(36));
    check({tag, "_done_pulses"}, 128'(done_cnt), 128'(1));
    check({tag, "_cfg_loaded"}, 128'(cfg_loaded), 128'(exp_loaded));
    check({tag, "_cfg_error"}, 128'(cfg_error), 128'(exp_error));
    check({tag, "_busy_after"}, 128'(busy), 128'(0));
    check({tag, "_bits_left_end"}, 128'(bits_left), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = 32'hA5A5A5A5;
    words[1] = 32'h0F0F0F0F;
    words[2] = 32'hFC000000;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    repeat (3) @(posedge prog_clk);
    #1;
    check("rst_prog_en", 128'(prog_en), 128'(0));
    check("rst_prog_in", 128'(prog_in), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_cfg_loaded", 128'(cfg_loaded), 128'(0));
    check("rst_cfg_error", 128'(cfg_error), 128'(0));
    check("rst_bits_left", 128'(bits_left), 128'(0));
    check("rst_s_ready", 128'(s_if.s_ready), 128'(0));
    rst = 1'b0;
    @(posedge prog_clk);
    #1;

    run_load(0, 0, 0, 16'h1234);
    check_full("contig", 70, 1, 1'b1, 1'b0);

    s_if.s_valid = 1'b1;
    s_if.s_data  = words[0];
    repeat (4) step(hs_idle);
    check("idle_s_ready", 128'(s_if.s_ready), 128'(0));
    check("idle_no_hs", 128'(hs_idle), 128'(0));
    check("idle_prog_en", 128'(prog_en), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
    s_if.s_valid = 1'b0;

    run_load(5, 0, 0, 16'h1234);
    check_full("gap", 75, 2, 1'b1, 1'b0);

    run_load(0, 10, 2, 16'h1234);
    check_full("start_busy", 70, 1, 1'b1, 1'b0);

    run_load(0, 40, 1, 16'h1234);
    check("abort_en_cycles", 128'(en_cycles), 128'(41));
    check("abort_done_cnt", 128'(done_cnt), 128'(0));

    run_load(0, 0, 0, 16'h1234);
    check_full("after_abort", 70, 1, 1'b1, 1'b0);

    run_load(0, 20, 3, 16'h1234);
    check("rstmid_en_cycles", 128'(en_cycles), 128'(21));

    run_load(0, 0, 0, 16'h1234);
    check_full("after_rst", 70, 1, 1'b1, 1'b0);

`ifdef PROG_CRC_EN
    run_load(0, 0, 0, crc_of(EXP_BITS));
    check_full("crc_ok", 70, 1, 1'b1, 1'b0);
    run_load(0, 0, 0, crc_of(EXP_BITS) ^ 16'h0001);
    check_full("crc_bad", 70, 1, 1'b0, 1'b1);
`else
    run_load(0, 0, 0, 16'hBEEF);
    check_full("crc_off", 70, 1, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
